// File: rtl/button_conditioner.sv
// Five-button front end: two-flop synchronizers, per-button debounce FSMs with press pulses,
// and a registered priority encoder that emits one key event per accepted press.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       CLK100MHZ,
  input  logic       RST,
  input  logic       BTNU,
  input  logic       BTND,
  input  logic       BTNL,
  input  logic       BTNR,
  input  logic       BTNC,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse,
  output logic       key_valid,
  output logic [2:0] key_code,
  output logic       any_held
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       btn_raw;
  logic [4:0]       sync1_q, sync2_q;
  state_e           state_q [5];
  state_e           state_d [5];
  logic [CNT_W-1:0] cnt_q   [5];
  logic [CNT_W-1:0] cnt_d   [5];
  logic [4:0]       level_q, level_d;
  logic [4:0]       pulse_q, pulse_d;
  logic             key_valid_q, key_valid_d;
  logic [2:0]       key_code_q, key_code_d;

  assign btn_raw = {BTNC, BTNR, BTNL, BTND, BTNU};

  always_comb begin
    level_d = '0;
    pulse_d = '0;
    for (int i = 0; i < 5; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        StIdle: begin
          if (sync2_q[i]) begin
            state_d[i] = StPressWait;
            cnt_d[i]   = '0;
          end
        end
        StPressWait: begin
          if (!sync2_q[i]) begin
            state_d[i] = StIdle;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StHeld;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        StHeld: begin
          if (!sync2_q[i]) begin
            state_d[i] = StReleaseWait;
            cnt_d[i]   = '0;
          end
        end
        StReleaseWait: begin
          if (sync2_q[i]) begin
            state_d[i] = StHeld;
          end else if (cnt_q[i] == CntMax) begin
            state_d[i] = StIdle;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = StIdle;
      endcase
      // Level tracks the next state so it registers alongside it.
      level_d[i] = (state_d[i] == StHeld) || (state_d[i] == StReleaseWait);
    end
  end

  // Lowest index wins; simultaneous losers are intentionally dropped.
  always_comb begin
    key_valid_d = |pulse_q;
    key_code_d  = 3'd0;
    if (pulse_q[0]) begin
      key_code_d = 3'd1;
    end else if (pulse_q[1]) begin
      key_code_d = 3'd2;
    end else if (pulse_q[2]) begin
      key_code_d = 3'd3;
    end else if (pulse_q[3]) begin
      key_code_d = 3'd4;
    end else if (pulse_q[4]) begin
      key_code_d = 3'd5;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      pulse_q     <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      pulse_q     <= pulse_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      for (int i = 0; i < 5; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign any_held  = |level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_conditioner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnu, btnd, btnl, btnr, btnc;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic       key_valid;
  logic [2:0] key_code;
  logic       any_held;

  int checks   = 0;
  int failures = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .CLK100MHZ(clk),
    .RST      (rst),
    .BTNU     (btnu),
    .BTND     (btnd),
    .BTNL     (btnl),
    .BTNR     (btnr),
    .BTNC     (btnc),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .key_valid(key_valid),
    .key_code (key_code),
    .any_held (any_held)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btnu = 0; btnd = 0; btnl = 0; btnr = 0; btnc = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    do_reset();
    obs = {btn_level, btn_pulse, key_valid};
    checks++;
    if (obs !== 11'd0 || key_code !== 3'd0 || any_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got lvl=%b pulse=%b kv=%b code=%0d held=%b, want all 0",
               btn_level, btn_pulse, key_valid, key_code, any_held);
    end
    // Reach the pulse cycle, then reset while level and pulse are high.
    btnu = 1;
    for (int j = 0; j <= N + 2; j++) tick();
    checks++;
    if (btn_pulse !== 5'b00001 || btn_level !== 5'b00001) begin
      failures++;
      $display("FAIL reset_precond: got pulse=%b lvl=%b, want 00001/00001", btn_pulse, btn_level);
    end
    rst = 1;
    tick();
    obs = {btn_level, btn_pulse, key_valid};
    checks++;
    if (obs !== 11'd0 || key_code !== 3'd0 || any_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears: got lvl=%b pulse=%b kv=%b code=%0d held=%b, want all 0",
               btn_level, btn_pulse, key_valid, key_code, any_held);
    end
    rst = 0;
    btnu = 0;
  endtask

  task automatic test_clean_press();
    do_reset();
    btnu = 1;
    for (int j = 0; j <= N + 8; j++) begin
      tick();
      checks++;
      if (btn_pulse[0] !== (j == N + 2) || btn_level[0] !== (j >= N + 2) ||
          any_held !== (j >= N + 2)) begin
        failures++;
        $display("FAIL clean_press_pulse j=%0d: got pulse0=%b lvl0=%b held=%b, want %b %b %b", j,
                 btn_pulse[0], btn_level[0], any_held, j == N + 2, j >= N + 2, j >= N + 2);
      end
      checks++;
      if (key_valid !== (j == N + 3) || key_code !== ((j == N + 3) ? 3'd1 : 3'd0)) begin
        failures++;
        $display("FAIL clean_press_key j=%0d: got kv=%b code=%0d, want kv=%b code=%0d", j,
                 key_valid, key_code, j == N + 3, (j == N + 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] pat [4];
    do_reset();
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0;
    for (int j = 0; j < 24; j++) begin
      btnl = (j < 4) ? pat[j][0] : 1'b0;
      tick();
      checks++;
      if (btn_pulse !== 5'd0 || key_valid !== 1'b0 || btn_level[2] !== 1'b0) begin
        failures++;
        $display("FAIL bounce j=%0d: got pulse=%b kv=%b lvl2=%b, want 0/0/0", j, btn_pulse,
                 key_valid, btn_level[2]);
      end
    end
  endtask

  task automatic test_simultaneous();
    int events = 0;
    do_reset();
    btnr = 1;
    btnd = 1;
    for (int j = 0; j <= N + 14; j++) begin
      tick();
      if (j == N + 2) begin
        checks++;
        if (btn_pulse !== 5'b01010) begin
          failures++;
          $display("FAIL simul_pulse: got %b, want 01010", btn_pulse);
        end
      end else if (btn_pulse !== 5'd0) begin
        checks++;
        failures++;
        $display("FAIL simul_pulse_extra j=%0d: got %b, want 00000", j, btn_pulse);
      end
      if (key_valid) begin
        events++;
        checks++;
        if (key_code !== 3'd2) begin
          failures++;
          $display("FAIL simul_code: got %0d, want 2", key_code);
        end
      end
    end
    checks++;
    if (events != 1) begin
      failures++;
      $display("FAIL simul_events: got %0d, want 1", events);
    end
  endtask

  task automatic test_hold_release();
    int events = 0;
    do_reset();
    btnc = 1;
    for (int j = 0; j < 50; j++) begin
      tick();
      if (key_valid) begin
        events++;
        checks++;
        if (key_code !== 3'd5) begin
          failures++;
          $display("FAIL hold_code1: got %0d, want 5", key_code);
        end
      end
    end
    btnc = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (btn_level[4] !== (j < N + 2)) begin
        failures++;
        $display("FAIL hold_release_level j=%0d: got %b, want %b", j, btn_level[4], j < N + 2);
      end
      if (key_valid) events++;
    end
    btnc = 1;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (key_valid) begin
        events++;
        checks++;
        if (key_code !== 3'd5) begin
          failures++;
          $display("FAIL hold_code2: got %0d, want 5", key_code);
        end
      end
    end
    checks++;
    if (events != 2) begin
      failures++;
      $display("FAIL hold_events: got %0d, want 2", events);
    end
  endtask

  task automatic test_release_glitch();
    int pulses = 0;
    do_reset();
    btnu = 1;
    for (int j = 0; j < 12; j++) tick();
    checks++;
    if (btn_level[0] !== 1'b1) begin
      failures++;
      $display("FAIL glitch_precond: got lvl0=%b, want 1", btn_level[0]);
    end
    for (int j = 0; j < 20; j++) begin
      btnu = (j == 0 || j == 1) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (btn_level[0] !== 1'b1) begin
        failures++;
        $display("FAIL glitch_level j=%0d: got %b, want 1", j, btn_level[0]);
      end
      if (btn_pulse[0] || key_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL glitch_repulse: got %0d pulse/event cycles, want 0", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    do_reset();
    btnc = 1;
    for (int j = 0; j < 4; j++) tick();
    rst = 1;
    tick();
    obs = {btn_level, btn_pulse, key_valid};
    checks++;
    if (obs !== 11'd0 || key_code !== 3'd0 || any_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: got lvl=%b pulse=%b kv=%b code=%0d, want all 0",
               btn_level, btn_pulse, key_valid, key_code);
    end
    rst = 0;
    for (int j = 0; j <= N + 6; j++) begin
      tick();
      checks++;
      if (key_valid !== (j == N + 3) || key_code !== ((j == N + 3) ? 3'd5 : 3'd0)) begin
        failures++;
        $display("FAIL reset_mid_key j=%0d: got kv=%b code=%0d, want kv=%b code=%0d", j,
                 key_valid, key_code, j == N + 3, (j == N + 3) ? 5 : 0);
      end
    end
  endtask

  initial begin
    rst = 1;
    btnu = 0; btnd = 0; btnl = 0; btnr = 0; btnc = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_hold_release();
    test_release_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
